// File: rtl/sync_fifo_pkg.sv
// Shared constants, types and sizing helpers for the synchronous byte FIFO.
package sync_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 16;

  typedef logic [7:0] fifo_byte_t;

  // Occupancy must represent 0..depth inclusive, hence depth+1 states.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array: synchronous write, registered read-first read.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_array[waddr] <= wdata;
    end
  end

  // Output register only is cleared; a same-address write returns the old word.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem_array[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointer/occupancy bookkeeping, accept logic and registered
// status flags around a registered-read storage array.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          full_reg, empty_reg, almost_full_reg, almost_empty_reg;
  logic          rd_valid_reg, overflow_reg, underflow_reg;
  logic          rd_acc, wr_acc;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc      = rd_en & ~empty_reg;
    wr_acc      = wr_en & (~full_reg | rd_acc);
    wr_ptr_next = wr_acc ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next = rd_acc ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    count_next  = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Flags come from count_next so they line up with count in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      rd_valid_reg     <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      full_reg         <= (count_next == CW'(DEPTH));
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= CW'(AF_LEVEL));
      almost_empty_reg <= (count_next <= CW'(AE_LEVEL));
      rd_valid_reg     <= rd_acc;
      overflow_reg     <= wr_en & ~wr_acc;
      underflow_reg    <= rd_en & ~rd_acc;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (wr_acc & reset_n),
    .waddr   (wr_ptr_reg),
    .wdata   (wr_data),
    .re      (rd_acc & reset_n),
    .raddr   (rd_ptr_reg),
    .rdata   (rd_data)
  );

  assign rd_valid     = rd_valid_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (count_reg <= CW'(DEPTH));
      assert (!(full_reg && empty_reg));
      assert (AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH);
    end
  end
`endif

endmodule
